// File: rtl/periph_arb2_pkg.sv
// Shared definitions for the two-master peripheral arbiter.
//   state_t      : arbiter FSM states (idle / waiting for slave / error reply)
//   M0, M1       : master index values as carried on grant_o
//   ERR_DATA_DEF : default read data handed back when the watchdog fires
package periph_arb2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

endpackage

// File: rtl/periph_arb2_rr_pick2.sv
// Two-input round-robin picker, purely combinational.
//   req[1:0] : request bits of master 1 / master 0
//   last     : index of the master served most recently
//   winner   : chosen master index (0 when nobody requests)
//   any      : at least one request is present
module periph_arb2_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       winner,
    output logic       any
);

    always_comb begin
        any = |req;
        // A tie goes to whoever was not served last; otherwise the lone requester.
        if (req == 2'b11) begin
            winner = ~last;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/periph_arb2.sv
// Arbiter sharing one single-outstanding valid/ready peripheral slave between
// the core LSU (m0) and the debug master (m1). Grant is per transaction and is
// held from request handshake to response handshake. A response watchdog
// answers a hung transaction with ERR_DATA so no master deadlocks.
//   clk, rst                : clock, synchronous active-high reset
//   m0_* / m1_*             : master request/response ports
//   s_*                     : forwarded slave port
//   timeout_o               : one-cycle pulse when the watchdog expires
//   grant_o                 : current or most recently granted master
module periph_arb2
    import periph_arb2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 256,
    parameter logic [31:0] ERR_DATA    = ERR_DATA_DEF,
    parameter int unsigned CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] m0_addr_i,
    input  logic [31:0] m0_data_i,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_we_i,
    output logic [31:0] m0_data_o,
    input  logic        m0_req_valid_i,
    output logic        m0_req_ready_o,
    output logic        m0_rsp_valid_o,
    input  logic        m0_rsp_ready_i,

    input  logic [31:0] m1_addr_i,
    input  logic [31:0] m1_data_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    output logic [31:0] m1_data_o,
    input  logic        m1_req_valid_i,
    output logic        m1_req_ready_o,
    output logic        m1_rsp_valid_o,
    input  logic        m1_rsp_ready_i,

    output logic [31:0] s_addr_o,
    output logic [31:0] s_data_o,
    output logic [3:0]  s_sel_o,
    output logic        s_we_o,
    input  logic [31:0] s_data_i,
    output logic        s_req_valid_o,
    input  logic        s_req_ready_i,
    input  logic        s_rsp_valid_i,
    output logic        s_rsp_ready_o,

    output logic        timeout_o,
    output logic        grant_o
);

    localparam bit              WD_EN    = (TIMEOUT_CYC != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t           state_q, state_d;
    logic             gnt_q, gnt_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic winner;
    logic any;
    logic gnt_rsp_ready;

    periph_arb2_rr_pick2 u_pick (
        .req    ({m1_req_valid_i, m0_req_valid_i}),
        .last   (last_q),
        .winner (winner),
        .any    (any)
    );

    assign gnt_rsp_ready = (gnt_q == M1) ? m1_rsp_ready_i : m0_rsp_ready_i;
    assign grant_o       = gnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= M0;
            last_q  <= M1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        gnt_d          = gnt_q;
        last_d         = last_q;
        cnt_d          = cnt_q;

        s_addr_o       = '0;
        s_data_o       = '0;
        s_sel_o        = '0;
        s_we_o         = 1'b0;
        s_req_valid_o  = 1'b0;
        s_rsp_ready_o  = 1'b0;
        m0_req_ready_o = 1'b0;
        m1_req_ready_o = 1'b0;
        m0_rsp_valid_o = 1'b0;
        m1_rsp_valid_o = 1'b0;
        m0_data_o      = '0;
        m1_data_o      = '0;
        timeout_o      = 1'b0;

        // Outputs stay quiet while reset is held, whatever the state register holds.
        if (!rst) begin
            unique case (state_q)
                ST_IDLE: begin
                    // Drain stray or late slave responses while nobody owns the bus.
                    s_rsp_ready_o = 1'b1;
                    if (any) begin
                        s_req_valid_o = 1'b1;
                        if (winner == M1) begin
                            s_addr_o       = m1_addr_i;
                            s_data_o       = m1_data_i;
                            s_sel_o        = m1_sel_i;
                            s_we_o         = m1_we_i;
                            m1_req_ready_o = s_req_ready_i;
                        end else begin
                            s_addr_o       = m0_addr_i;
                            s_data_o       = m0_data_i;
                            s_sel_o        = m0_sel_i;
                            s_we_o         = m0_we_i;
                            m0_req_ready_o = s_req_ready_i;
                        end
                        if (s_req_ready_i) begin
                            gnt_d   = winner;
                            cnt_d   = '0;
                            state_d = ST_WAIT;
                        end
                    end
                end

                ST_WAIT: begin
                    s_rsp_ready_o = gnt_rsp_ready;
                    if (gnt_q == M1) begin
                        m1_rsp_valid_o = s_rsp_valid_i;
                        m1_data_o      = s_data_i;
                    end else begin
                        m0_rsp_valid_o = s_rsp_valid_i;
                        m0_data_o      = s_data_i;
                    end
                    if (s_rsp_valid_i) begin
                        // A presented response stalls the watchdog even if the master is slow.
                        if (gnt_rsp_ready) begin
                            last_d  = gnt_q;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                        if (WD_EN && (cnt_q == CNT_LAST)) begin
                            timeout_o = 1'b1;
                            state_d   = ST_ERR;
                        end
                    end
                end

                ST_ERR: begin
                    s_rsp_ready_o = 1'b1;
                    if (gnt_q == M1) begin
                        m1_rsp_valid_o = 1'b1;
                        m1_data_o      = ERR_DATA;
                    end else begin
                        m0_rsp_valid_o = 1'b1;
                        m0_data_o      = ERR_DATA;
                    end
                    if (gnt_rsp_ready) begin
                        last_d  = gnt_q;
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
